// File: rtl/sound_player_if.sv
// Control and audio-status bundle between the game-state controller and sound_player.
interface sound_player_if;
  logic [2:0] sound_select;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] note_idx;

  modport master (
    output sound_select,
    output mute,
    input  speaker,
    input  busy,
    input  note_idx
  );

  modport slave (
    input  sound_select,
    input  mute,
    output speaker,
    output busy,
    output note_idx
  );
endinterface

// File: rtl/sound_player.sv
// Square-wave note-sequence player: a change of sound_select to codes 1..4 starts
// (or preempts with) that code's note table, played as notes separated by silent gaps.
module sound_player #(
  parameter int TONE_UNIT = 1000,
  parameter int NOTE_LEN  = 2_500_000,
  parameter int GAP_LEN   = 250_000
) (
  input  logic           clk,
  input  logic           reset,
  sound_player_if.slave  bus
);

  localparam int HP_W    = $clog2(48 * TONE_UNIT);
  localparam int DUR_MAX = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int DUR_W   = ($clog2(DUR_MAX) < 1) ? 1 : $clog2(DUR_MAX);
  localparam logic [31:0] NOTE_TERM = 32'(NOTE_LEN - 1);
  localparam logic [31:0] GAP_TERM  = 32'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [5:0] tone_entry(input logic [2:0] code, input logic [1:0] idx);
    logic [5:0] n;
    n = 6'd0;
    case (code)
      3'd1: begin
        case (idx)
          2'd0:    n = 6'd24;
          default: n = 6'd0;
        endcase
      end
      3'd2: begin
        case (idx)
          2'd0:    n = 6'd32;
          2'd1:    n = 6'd27;
          2'd2:    n = 6'd24;
          default: n = 6'd0;
        endcase
      end
      3'd3: begin
        case (idx)
          2'd0:    n = 6'd36;
          2'd1:    n = 6'd40;
          2'd2:    n = 6'd48;
          default: n = 6'd0;
        endcase
      end
      3'd4: begin
        case (idx)
          2'd0:    n = 6'd32;
          2'd1:    n = 6'd27;
          2'd2:    n = 6'd24;
          default: n = 6'd16;
        endcase
      end
      default: n = 6'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] last_idx(input logic [2:0] code);
    logic [1:0] l;
    case (code)
      3'd2:    l = 2'd2;
      3'd3:    l = 2'd2;
      3'd4:    l = 2'd3;
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  function automatic logic valid_code(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  state_t            state_r;
  state_t            state_n;
  logic [2:0]        prev_sel_r;
  logic [2:0]        seq_code_r;
  logic [1:0]        note_idx_r;
  logic [DUR_W-1:0]  dur_cnt_r;
  logic [HP_W-1:0]   hp_cnt_r;
  logic              tone_r;

  logic              trig_s;
  logic [5:0]        note_n_s;
  logic [31:0]       hp_lim_s;
  logic              hp_term_s;
  logic              dur_term_s;
  logic              gap_term_s;
  logic              last_s;
  logic              start_s;
  logic              next_s;

  assign trig_s     = (bus.sound_select != prev_sel_r) && valid_code(bus.sound_select);
  assign note_n_s   = tone_entry(seq_code_r, note_idx_r);
  assign hp_lim_s   = 32'(TONE_UNIT) * {26'd0, note_n_s};
  assign hp_term_s  = (32'(hp_cnt_r) == (hp_lim_s - 32'd1));
  assign dur_term_s = (32'(dur_cnt_r) == NOTE_TERM);
  assign gap_term_s = (32'(dur_cnt_r) == GAP_TERM);
  assign last_s     = (note_idx_r == last_idx(seq_code_r));

  assign bus.speaker  = tone_r & ~bus.mute;
  assign bus.busy     = (state_r != IDLE);
  assign bus.note_idx = note_idx_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; a trigger outranks any terminal count in the same cycle.
  always_comb begin
    state_n = state_r;
    start_s = 1'b0;
    next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          state_n = PLAY;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      PLAY: begin
        if (trig_s) begin
          state_n = PLAY;
          start_s = 1'b1;
        end else if (dur_term_s) begin
          if (last_s) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
          end
        end else begin
          state_n = PLAY;
        end
      end
      GAP: begin
        if (trig_s) begin
          state_n = PLAY;
          start_s = 1'b1;
        end else if (gap_term_s) begin
          state_n = PLAY;
          next_s  = 1'b1;
        end else begin
          state_n = GAP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Sequencing datapath: selected code, note index, duration and half-period counters, tone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sel_r <= 3'd0;
      seq_code_r <= 3'd0;
      note_idx_r <= 2'd0;
      dur_cnt_r  <= '0;
      hp_cnt_r   <= '0;
      tone_r     <= 1'b0;
    end else begin
      prev_sel_r <= bus.sound_select;
      if (start_s) begin
        seq_code_r <= bus.sound_select;
        note_idx_r <= 2'd0;
        dur_cnt_r  <= '0;
        hp_cnt_r   <= '0;
        tone_r     <= 1'b0;
      end else if (next_s) begin
        note_idx_r <= note_idx_r + 2'd1;
        dur_cnt_r  <= '0;
        hp_cnt_r   <= '0;
        tone_r     <= 1'b0;
      end else if (state_r == PLAY) begin
        if (dur_term_s) begin
          // Leaving the note: the gap (or idle) must start silent.
          dur_cnt_r <= '0;
          hp_cnt_r  <= '0;
          tone_r    <= 1'b0;
        end else if (note_n_s == 6'd0) begin
          dur_cnt_r <= dur_cnt_r + DUR_W'(1'b1);
          hp_cnt_r  <= '0;
          tone_r    <= 1'b0;
        end else if (hp_term_s) begin
          dur_cnt_r <= dur_cnt_r + DUR_W'(1'b1);
          hp_cnt_r  <= '0;
          tone_r    <= ~tone_r;
        end else begin
          dur_cnt_r <= dur_cnt_r + DUR_W'(1'b1);
          hp_cnt_r  <= hp_cnt_r + HP_W'(1'b1);
        end
      end else if (state_r == GAP) begin
        dur_cnt_r <= dur_cnt_r + DUR_W'(1'b1);
        hp_cnt_r  <= '0;
        tone_r    <= 1'b0;
      end else begin
        dur_cnt_r <= '0;
        hp_cnt_r  <= '0;
        tone_r    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Scoreboard bench for sound_player: stimulus queues expected output changes, a
// negedge monitor pops and compares them whenever busy/speaker/note_idx change.
module tb_sound_player;

  localparam int T = 1;
  localparam int N = 64;
  localparam int G = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sound_player_if bus ();

  sound_player #(.TONE_UNIT(T), .NOTE_LEN(N), .GAP_LEN(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       b;
    logic       s;
    logic [1:0] i;
  } ev_t;

  ev_t  exp_q[$];
  int   len_q[$];
  logic eb = 1'b0;
  logic es = 1'b0;
  logic [1:0] ei = 2'd0;
  int   mute_lo = 0;
  int   mute_hi = 0;

  function automatic int tb_note(input int code, input int i);
    case (code * 4 + i)
      4:       return 24;
      8:       return 32;
      9:       return 27;
      10:      return 24;
      12:      return 36;
      13:      return 40;
      14:      return 48;
      16:      return 32;
      17:      return 27;
      18:      return 24;
      19:      return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int tb_len(input int code);
    case (code)
      1:       return 1;
      2:       return 3;
      3:       return 3;
      4:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic ok, input int act, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic update_exp(input int c, input logic b, input logic s, input logic [1:0] i);
    ev_t e;
    if (b != eb || s != es || i != ei) begin
      e.c = c; e.b = b; e.s = s; e.i = i;
      exp_q.push_back(e);
      eb = b; es = s; ei = i;
    end
  endtask

  // Expected outputs per cycle c in [from,to) for a sequence of `code` started at edge s.
  task automatic model_window(input int s, input int code, input int from, input int to);
    int L, per, t, k, off, h;
    logic b, sp;
    logic [1:0] ix;
    L = tb_len(code);
    per = N + G;
    for (int c = from; c < to; c++) begin
      t = c - s;
      k = t / per;
      off = t % per;
      if (t >= L * N + (L - 1) * G) begin
        b = 1'b0; sp = 1'b0; ix = 2'(L - 1);
      end else if (off < N) begin
        b = 1'b1; ix = 2'(k);
        h = tb_note(code, k) * T;
        sp = (h == 0) ? 1'b0 : 1'((off / h) % 2);
      end else begin
        b = 1'b1; sp = 1'b0; ix = 2'(k);
      end
      if (c >= mute_lo && c < mute_hi) sp = 1'b0;
      update_exp(c, b, sp, ix);
    end
  endtask

  task automatic start_code(input logic [2:0] v, output int s);
    @(posedge clk);
    #1;
    bus.sound_select = v;
    s = cyc + 1;
  endtask

  logic       mb = 1'b0;
  logic       ms = 1'b0;
  logic [1:0] mi = 2'd0;
  int         rise = 0;

  // Monitor: every output change is matched against the next queued expectation.
  always @(negedge clk) begin
    if (bus.busy !== mb || bus.speaker !== ms || bus.note_idx !== mi) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: cyc=%0d got busy=%0b spk=%0b idx=%0d, want no change",
                 cyc, bus.busy, bus.speaker, bus.note_idx);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        if (e.c != cyc || e.b !== bus.busy || e.s !== bus.speaker || e.i !== bus.note_idx) begin
          errors++;
          $display("FAIL output_change: got cyc=%0d busy=%0b spk=%0b idx=%0d, want cyc=%0d busy=%0b spk=%0b idx=%0d",
                   cyc, bus.busy, bus.speaker, bus.note_idx, e.c, e.b, e.s, e.i);
        end
      end
      if (bus.busy && !mb) rise = cyc;
      if (!bus.busy && mb && !reset) begin
        if (len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_length: got %0d, want no busy period", cyc - rise);
        end else begin
          int want;
          want = len_q.pop_front();
          check("busy_length", (cyc - rise) == want, cyc - rise, want);
        end
      end
      mb = bus.busy;
      ms = bus.speaker;
      mi = bus.note_idx;
    end
  end

  initial begin
    int s, s2, d;
    bus.sound_select = 3'd0;
    bus.mute = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    check("reset_speaker", bus.speaker == 1'b0, int'(bus.speaker), 0);
    check("reset_note_idx", bus.note_idx == 2'd0, int'(bus.note_idx), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Hop.
    start_code(3'd1, s);
    model_window(s, 1, s, s + 80);
    len_q.push_back(64);
    repeat (80) @(posedge clk);

    // Level up.
    start_code(3'd0, d);
    start_code(3'd2, s);
    model_window(s, 2, s, s + 220);
    len_q.push_back(208);
    repeat (220) @(posedge clk);

    // Preempt hop with death at cycle 30, hold, then 3->0->3 retrigger.
    start_code(3'd0, d);
    start_code(3'd1, s);
    model_window(s, 1, s, s + 30);
    model_window(s + 30, 3, s + 30, s + 270);
    len_q.push_back(238);
    repeat (29) @(posedge clk);
    start_code(3'd3, s2);
    repeat (240) @(posedge clk);
    start_code(3'd0, d);
    start_code(3'd3, s);
    model_window(s, 3, s, s + 220);
    len_q.push_back(208);
    repeat (220) @(posedge clk);

    // Reserved and zero codes.
    start_code(3'd0, d);
    start_code(3'd5, d);
    repeat (5) @(posedge clk);
    start_code(3'd6, d);
    repeat (5) @(posedge clk);
    start_code(3'd7, d);
    start_code(3'd0, d);
    start_code(3'd4, s);
    model_window(s, 4, s, s + 300);
    len_q.push_back(280);
    repeat (99) @(posedge clk);
    start_code(3'd0, d);
    repeat (210) @(posedge clk);

    // Mute over the start of code 4.
    @(posedge clk);
    #1;
    bus.mute = 1'b1;
    start_code(3'd4, s);
    mute_lo = s;
    mute_hi = s + 99;
    model_window(s, 4, s, s + 300);
    len_q.push_back(280);
    repeat (100) @(posedge clk);
    #1;
    bus.mute = 1'b0;
    repeat (205) @(posedge clk);
    mute_hi = 0;

    // Asynchronous reset in note 1 of code 2, released with code 2 held.
    start_code(3'd0, d);
    start_code(3'd2, s);
    model_window(s, 2, s, s + 102);
    repeat (103) @(posedge clk);
    update_exp(s + 102, 1'b0, 1'b0, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    check("async_reset_speaker", bus.speaker == 1'b0, int'(bus.speaker), 0);
    check("async_reset_note_idx", bus.note_idx == 2'd0, int'(bus.note_idx), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    s = cyc + 1;
    model_window(s, 2, s, s + 220);
    len_q.push_back(208);
    repeat (220) @(posedge clk);

    repeat (5) @(posedge clk);
    check("expected_changes_left", exp_q.size() == 0, exp_q.size(), 0);
    check("busy_lengths_left", len_q.size() == 0, len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
